// File: rtl/io_bus_pkg.sv
// Shared definitions for the I/O register bank: register modes, bus FSM states
// and the width helper used for byte-strobe sizing.
package io_bus_pkg;

  localparam logic [1:0] REG_MODE_RW  = 2'd0;
  localparam logic [1:0] REG_MODE_RO  = 2'd1;
  localparam logic [1:0] REG_MODE_W1C = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    RELEASE = 2'd2
  } bus_state_t;

  function automatic int BYTES(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/io_reg_cell.sv
// One bank register: read/write with byte strobes, hardware-mirrored read-only,
// or write-1-to-clear status with hardware set pulses.
module io_reg_cell
  import io_bus_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [1:0]            MODE       = REG_MODE_RW,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [BYTES(DATA_WIDTH)-1:0] byte_en,
  input  logic [DATA_WIDTH-1:0]        hw_in,
  input  logic [DATA_WIDTH-1:0]        hw_set,
  output logic [DATA_WIDTH-1:0]        value
);

  localparam int NB = BYTES(DATA_WIDTH);
  // Only RW (and the spare encoding that aliases it) carries a programmable reset image.
  localparam logic [DATA_WIDTH-1:0] INIT_VAL =
    (MODE == REG_MODE_RO || MODE == REG_MODE_W1C) ? '0 : RESET_VAL;

  logic [DATA_WIDTH-1:0] bit_mask;
  logic [DATA_WIDTH-1:0] value_d, value_q;

  always_comb begin
    for (int k = 0; k < NB; k++) begin
      bit_mask[k*8 +: 8] = {8{byte_en[k]}};
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves value_d unassigned (no latch).
    value_d = value_q;
    case (MODE)
      REG_MODE_RO:  value_d = hw_in;
      // Set is ORed after the clear so a same-cycle set wins.
      REG_MODE_W1C: value_d = (value_q & ~(wr_en ? (wr_data & bit_mask) : '0)) | hw_set;
      default: begin
        if (wr_en) value_d = (value_q & ~bit_mask) | (wr_data & bit_mask);
      end
    endcase
  end

  // NOTE: non-blocking assignment for state; async reset loads the reset image so no register powers up unknown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= INIT_VAL;
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/io_register_bank.sv
// Bank of NUM_REGS registers behind a tri-state enable/write/ready bus with a
// one-cycle registered ack, read latch and per-register write pulses.
module io_register_bank
  import io_bus_pkg::*;
#(
  parameter int                              DATA_WIDTH  = 32,
  parameter int                              NUM_REGS    = 4,
  parameter int                              ADDR_WIDTH  = 2,
  parameter logic [2*NUM_REGS-1:0]           REG_MODE    = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           enable,
  input  logic                           write,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [BYTES(DATA_WIDTH)-1:0]   byte_en,
  input  logic [DATA_WIDTH-1:0]          data_in,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           ready,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
  output logic [NUM_REGS*DATA_WIDTH-1:0] r_mem,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  bus_state_t            state_d, state_q;
  logic                  accept;
  logic [NUM_REGS-1:0]   wr_sel;
  logic [DATA_WIDTH-1:0] rd_sel;
  logic [DATA_WIDTH-1:0] rd_d, rd_q;
  logic [NUM_REGS-1:0]   wr_pulse_d, wr_pulse_q;
  logic                  ready_int;
  logic [DATA_WIDTH-1:0] data_int;

  assign accept = (state_q == IDLE) && enable;

  // Out-of-range addresses match no index: no write, no pulse, read of zero.
  always_comb begin
    wr_sel = '0;
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(addr) == i) begin
        wr_sel[i] = accept && write;
        rd_sel    = r_mem[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign rd_d       = accept ? rd_sel : rd_q;
  assign wr_pulse_d = wr_sel;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      wr_pulse_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = ACK;
      ACK:     state_d = enable ? RELEASE : IDLE;
      RELEASE: if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_int = 1'b0;
    data_int  = '0;
    if (state_q == ACK) begin
      ready_int = 1'b1;
      data_int  = rd_q;
    end
  end

  assign ready    = enable ? ready_int : 1'bz;
  assign data_out = enable ? data_int  : {DATA_WIDTH{1'bz}};
  assign wr_pulse = wr_pulse_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    io_reg_cell #(
      .DATA_WIDTH (DATA_WIDTH),
      .MODE       (REG_MODE[2*i +: 2]),
      .RESET_VAL  (RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH])
    ) u_cell (
      .clk     (clk_in),
      .rst_n   (rst_n_in),
      .wr_en   (wr_sel[i]),
      .wr_data (data_in),
      .byte_en (byte_en),
      .hw_in   (hw_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .hw_set  (hw_set[i*DATA_WIDTH +: DATA_WIDTH]),
      .value   (r_mem[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_io_register_bank.sv
// Scoreboard bench for io_register_bank: a 4-register bank (RW, RW, W1C, RO)
// and a 3-register bank reached with an out-of-range address.
module tb_io_register_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main bank: reg0 RW, reg1 RW (reset 0xDEADBEEF), reg2 W1C, reg3 RO.
  logic         en_m = 1'b0, wr_m = 1'b0;
  logic [1:0]   addr_m = '0;
  logic [3:0]   be_m = '0;
  logic [31:0]  din_m = '0;
  logic [127:0] hw_in_m = '0, hw_set_m = '0;
  wire  [31:0]  dout_m;
  wire          rdy_m;
  wire  [127:0] rmem_m;
  wire  [3:0]   pulse_m;

  // Small bank: three RW registers, reg2 reset 0x5A5A5A5A, address 3 is out of range.
  logic         en_s = 1'b0, wr_s = 1'b0;
  logic [1:0]   addr_s = '0;
  logic [3:0]   be_s = '0;
  logic [31:0]  din_s = '0;
  logic [95:0]  hw_in_s = '0, hw_set_s = '0;
  wire  [31:0]  dout_s;
  wire          rdy_s;
  wire  [95:0]  rmem_s;
  wire  [2:0]   pulse_s;

  io_register_bank #(
    .DATA_WIDTH (32), .NUM_REGS (4), .ADDR_WIDTH (2),
    .REG_MODE   (8'b01_10_00_00),
    .RESET_VALUE({32'h0, 32'h0, 32'hDEADBEEF, 32'h0})
  ) dut_m (
    .clk_in (clk), .rst_n_in (rst_n), .enable (en_m), .write (wr_m), .addr (addr_m),
    .byte_en (be_m), .data_in (din_m), .data_out (dout_m), .ready (rdy_m),
    .hw_in (hw_in_m), .hw_set (hw_set_m), .r_mem (rmem_m), .wr_pulse (pulse_m)
  );

  io_register_bank #(
    .DATA_WIDTH (32), .NUM_REGS (3), .ADDR_WIDTH (2),
    .REG_MODE   (6'b00_00_00),
    .RESET_VALUE({32'h5A5A5A5A, 32'h0, 32'h0})
  ) dut_s (
    .clk_in (clk), .rst_n_in (rst_n), .enable (en_s), .write (wr_s), .addr (addr_s),
    .byte_en (be_s), .data_in (din_s), .data_out (dout_s), .ready (rdy_s),
    .hw_in (hw_in_s), .hw_set (hw_set_s), .r_mem (rmem_s), .wr_pulse (pulse_s)
  );

  typedef struct {
    bit          chk_data;
    logic [31:0] data;
    logic [3:0]  pulse;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic get_rdy(input bit sm);
    return sm ? rdy_s : rdy_m;
  endfunction

  function automatic logic [31:0] get_dout(input bit sm);
    return sm ? dout_s : dout_m;
  endfunction

  function automatic logic [3:0] get_pulse(input bit sm);
    return sm ? {1'b0, pulse_s} : pulse_m;
  endfunction

  // Released bus: must not be driven high; Z where the simulator keeps it.
  function automatic bit bus_released(input bit sm);
    logic [31:0] d;
    d = get_dout(sm);
    return (get_rdy(sm) !== 1'b1) && ((d === 32'hzzzzzzzz) || (d === 32'h0));
  endfunction

  // One bus transaction; set2 is driven on reg2's hw_set for the accept edge only.
  task automatic txn(input bit sm, input string tag, input bit wr, input logic [1:0] a,
                     input logic [3:0] be, input logic [31:0] d, input logic [31:0] rexp,
                     input logic [3:0] pexp, input logic [31:0] set2);
    exp_t e;
    int   waited;
    @(posedge clk); #1;
    if (sm) begin en_s = 1'b1; wr_s = wr; addr_s = a; be_s = be; din_s = d; end
    else    begin en_m = 1'b1; wr_m = wr; addr_m = a; be_m = be; din_m = d; end
    hw_set_m[64 +: 32] = set2;
    sb_q.push_back('{chk_data: !wr, data: rexp, pulse: pexp});
    @(negedge clk);
    check({tag, "_rdy_pre"}, {31'b0, get_rdy(sm)}, 32'd0);
    check({tag, "_dout_pre"}, get_dout(sm), 32'd0);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (get_rdy(sm) !== 1'b1 && waited < 6);
    hw_set_m = '0;
    check({tag, "_latency"}, waited, 32'd1);
    e = sb_q.pop_front();
    if (get_rdy(sm) === 1'b1) begin
      if (e.chk_data) check({tag, "_data"}, get_dout(sm), e.data);
      check({tag, "_pulse"}, {28'b0, get_pulse(sm)}, {28'b0, e.pulse});
    end
    @(posedge clk); #1;
    check({tag, "_rdy_release"}, {31'b0, get_rdy(sm)}, 32'd0);
    check({tag, "_pulse_off"}, {28'b0, get_pulse(sm)}, 32'd0);
    if (sm) begin en_s = 1'b0; wr_s = 1'b0; end
    else    begin en_m = 1'b0; wr_m = 1'b0; end
    @(negedge clk);
    check({tag, "_bus_z"}, {31'b0, bus_released(sm)}, 32'd1);
  endtask

  initial begin
    hw_in_m[127:96] = 32'hCAFE0001;

    // Reset state, including the bus with enable high during reset.
    #12;
    check("rst_bus_z", {31'b0, bus_released(0)}, 32'd1);
    en_m = 1'b1;
    #1;
    check("rst_rdy_en", {31'b0, rdy_m}, 32'd0);
    check("rst_dout_en", dout_m, 32'd0);
    check("rst_reg0", rmem_m[31:0], 32'd0);
    check("rst_reg1", rmem_m[63:32], 32'hDEADBEEF);
    check("rst_reg2", rmem_m[95:64], 32'd0);
    check("rst_pulse", {28'b0, pulse_m}, 32'd0);
    check("rst_s_reg2", rmem_s[95:64], 32'h5A5A5A5A);
    en_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    txn(0, "rd1",      0, 2'd1, 4'h0,    32'h0,        32'hDEADBEEF, 4'b0000, 32'h0);
    txn(0, "wr0",      1, 2'd0, 4'b0101, 32'h11223344, 32'h0,        4'b0001, 32'h0);
    check("wr0_mem", rmem_m[31:0], 32'h00220044);
    txn(0, "rd0",      0, 2'd0, 4'h0,    32'h0,        32'h00220044, 4'b0000, 32'h0);
    txn(0, "wr0_nobe", 1, 2'd0, 4'h0,    32'hFFFFFFFF, 32'h0,        4'b0001, 32'h0);
    check("wr0_nobe_mem", rmem_m[31:0], 32'h00220044);

    // Preload the W1C register through its set input, then race set against clear.
    @(posedge clk); #1 hw_set_m[95:64] = 32'hF;
    @(posedge clk); #1 hw_set_m = '0;
    check("w1c_preload", rmem_m[95:64], 32'h0000000F);
    txn(0, "w1c",      1, 2'd2, 4'hF,    32'h3,        32'h0,        4'b0100, 32'h2);
    check("w1c_race", rmem_m[95:64], 32'h0000000E);
    txn(0, "w1c_rd",   0, 2'd2, 4'h0,    32'h0,        32'h0000000E, 4'b0000, 32'h0);

    txn(0, "ro_wr",    1, 2'd3, 4'hF,    32'hFFFFFFFF, 32'h0,        4'b1000, 32'h0);
    txn(0, "ro_rd",    0, 2'd3, 4'h0,    32'h0,        32'hCAFE0001, 4'b0000, 32'h0);
    @(posedge clk); #1 hw_in_m[127:96] = 32'h12345678;
    @(posedge clk); #1;
    check("ro_track", rmem_m[127:96], 32'h12345678);

    // Async reset while the ack is on the bus.
    @(posedge clk); #1;
    en_m = 1'b1; wr_m = 1'b1; addr_m = 2'd0; be_m = 4'hF; din_m = 32'hAAAAAAAA;
    @(posedge clk); #2;
    check("ack_rdy_before_rst", {31'b0, rdy_m}, 32'd1);
    check("ack_commit", rmem_m[31:0], 32'hAAAAAAAA);
    rst_n = 1'b0;
    #1;
    check("rst_ack_rdy", {31'b0, rdy_m}, 32'd0);
    check("rst_ack_reg0", rmem_m[31:0], 32'd0);
    check("rst_ack_reg1", rmem_m[63:32], 32'hDEADBEEF);
    check("rst_ack_reg2", rmem_m[95:64], 32'd0);
    @(negedge clk);
    en_m = 1'b0; wr_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    txn(0, "post_rst", 0, 2'd1, 4'h0,    32'h0,        32'hDEADBEEF, 4'b0000, 32'h0);

    // Out-of-range accesses on the three-register bank.
    txn(1, "oor_rd",   0, 2'd3, 4'h0,    32'h0,        32'h0,        4'b0000, 32'h0);
    txn(1, "oor_wr",   1, 2'd3, 4'hF,    32'hFFFFFFFF, 32'h0,        4'b0000, 32'h0);
    check("oor_mem", rmem_s[31:0] | rmem_s[63:32], 32'd0);
    check("oor_mem2", rmem_s[95:64], 32'h5A5A5A5A);
    txn(1, "s_wr1",    1, 2'd1, 4'hF,    32'h12345678, 32'h0,        4'b0010, 32'h0);
    txn(1, "s_rd1",    0, 2'd1, 4'h0,    32'h0,        32'h12345678, 4'b0000, 32'h0);
    txn(1, "s_rd2",    0, 2'd2, 4'h0,    32'h0,        32'h5A5A5A5A, 4'b0000, 32'h0);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
